// File: rtl/ask_symbol_source.sv
// ask_symbol_source
//   4-ASK symbol source with zero-stuffing upsampler. One symbol is emitted
//   every SPS sample enables; the other SPS-1 samples are zero. Symbols come
//   from a 15-bit PRBS (x^15+x^14+1, two bits per symbol, Gray mapped), a
//   one-shot impulse, a constant +LVL_HI, or silence, selected by mode.
//
// Ports
//   sys_clk    in   1   clock, all state on rising edge
//   reset      in   1   asynchronous, active-low
//   sam_clk_en in   1   sample-rate enable (one sys_clk wide)
//   sym_clk_en in   1   symbol-rate enable, resyncs the phase counter
//   mode       in   2   00 PRBS, 01 impulse, 10 constant +LVL_HI, 11 silent
//   x_out      out  18  signed s1.17 upsampled sample
//   sym_out    out  2   current symbol bits {b1,b0}
//   sym_valid  out  1   one-sys_clk pulse per emitted symbol
//   align_err  out  1   sticky: sym_clk_en seen off the internal symbol phase
module ask_symbol_source #(
  parameter int unsigned        SPS     = 4,
  parameter logic signed [17:0] LVL_LO  = 18'sd32768,
  parameter logic signed [17:0] LVL_HI  = 18'sd98304,
  parameter logic signed [17:0] IMP_AMP = 18'sd131071,
  parameter logic [14:0]        SEED    = 15'h0001
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic [1:0]         mode,
  output logic signed [17:0] x_out,
  output logic [1:0]         sym_out,
  output logic               sym_valid,
  output logic               align_err
);

  localparam int unsigned     PH_W    = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPS - 1);

  typedef enum logic [1:0] {
    MODE_PRBS   = 2'b00,
    MODE_IMP    = 2'b01,
    MODE_CONST  = 2'b10,
    MODE_SILENT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IMP_IDLE = 2'b00,
    IMP_FIRE = 2'b01,
    IMP_DONE = 2'b10
  } imp_e;

  logic [PH_W-1:0]    r_ph;
  logic [14:0]        r_lfsr;
  imp_e               r_imp;

  logic [PH_W-1:0]    w_ph_next;
  logic               w_sym_phase;
  logic               w_misalign;
  mode_e              w_mode;
  logic [14:0]        w_lfsr_src;
  logic [14:0]        w_lfsr_adv;
  logic [1:0]         w_bits;
  logic signed [17:0] w_prbs_level;

  // Gray map: 00 -HI, 01 -LO, 11 +LO, 10 +HI
  function automatic logic signed [17:0] gray_level(input logic [1:0] bits);
    logic signed [17:0] lvl;
    case (bits)
      2'b00:   lvl = -LVL_HI;
      2'b01:   lvl = -LVL_LO;
      2'b11:   lvl = LVL_LO;
      default: lvl = LVL_HI;
    endcase
    return lvl;
  endfunction

  always_comb begin
    w_ph_next = (r_ph == PH_LAST) ? '0 : r_ph + 1'b1;
    // A coincident sym_clk_en forces this sample onto the symbol phase
    w_sym_phase = sam_clk_en & (sym_clk_en | (w_ph_next == '0));
    // Any sym_clk_en that does not land where ph would wrap anyway is an error
    w_misalign = sym_clk_en & (~sam_clk_en | (w_ph_next != '0));
    w_mode = mode_e'(mode);
  end

  // Two Fibonacci shifts folded into one step: the bits leaving the top
  // are s[14] then s[13]; the two feedback bits enter at the bottom.
  always_comb begin
    w_lfsr_src   = (r_lfsr == '0) ? SEED : r_lfsr;
    w_bits       = {w_lfsr_src[14], w_lfsr_src[13]};
    w_lfsr_adv   = {w_lfsr_src[12:0],
                    w_lfsr_src[14] ^ w_lfsr_src[13],
                    w_lfsr_src[13] ^ w_lfsr_src[12]};
    w_prbs_level = gray_level(w_bits);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_ph      <= PH_LAST;
      r_lfsr    <= SEED;
      r_imp     <= IMP_IDLE;
      x_out     <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      align_err <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      if (w_misalign) begin
        align_err <= 1'b1;
      end
      if (sam_clk_en) begin
        r_ph  <= w_sym_phase ? '0 : w_ph_next;
        x_out <= '0;
        if (w_sym_phase) begin
          if (r_lfsr == '0) begin
            r_lfsr <= SEED;
          end
          case (w_mode)
            MODE_PRBS: begin
              r_lfsr    <= w_lfsr_adv;
              x_out     <= w_prbs_level;
              sym_out   <= w_bits;
              sym_valid <= 1'b1;
              r_imp     <= IMP_IDLE;
            end
            MODE_IMP: begin
              sym_out   <= 2'b10;
              sym_valid <= 1'b1;
              case (r_imp)
                IMP_IDLE: begin
                  x_out <= IMP_AMP;
                  r_imp <= IMP_FIRE;
                end
                default: r_imp <= IMP_DONE;
              endcase
            end
            MODE_CONST: begin
              x_out     <= LVL_HI;
              sym_out   <= 2'b10;
              sym_valid <= 1'b1;
              r_imp     <= IMP_IDLE;
            end
            MODE_SILENT: begin
              r_imp <= IMP_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ask_symbol_source.sv
module tb_ask_symbol_source;

  logic               sys_clk = 1'b0;
  logic               reset;
  logic               sam_clk_en;
  logic               sym_clk_en;
  logic [1:0]         mode;
  logic signed [17:0] x_out;
  logic [1:0]         sym_out;
  logic               sym_valid;
  logic               align_err;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [14:0] m_lfsr;
  logic [1:0]  m_sym;

  always #5 sys_clk = ~sys_clk;

  ask_symbol_source #(
    .SPS     (4),
    .LVL_LO  (18'sd32768),
    .LVL_HI  (18'sd98304),
    .IMP_AMP (18'sd131071),
    .SEED    (15'h0001)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .mode       (mode),
    .x_out      (x_out),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .align_err  (align_err)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] level(input logic [1:0] s);
    case (s)
      2'b00:   return -98304;
      2'b01:   return -32768;
      2'b11:   return 32768;
      default: return 98304;
    endcase
  endfunction

  // Serial reference LFSR: bit out is the MSB, feedback s14^s13 enters at bit 0
  task automatic model_symbol();
    logic b;
    for (int k = 0; k < 2; k++) begin
      b      = m_lfsr[14];
      m_sym  = {m_sym[0], b};
      m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
    end
  endtask

  task automatic sample(input logic sync);
    sam_clk_en = 1'b1;
    sym_clk_en = sync;
    @(posedge sys_clk);
    #1;
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
  endtask

  task automatic gap(input int unsigned n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Three zero-stuffed samples after a symbol
  task automatic zeros(input string tag, input int unsigned idle);
    for (int unsigned k = 0; k < 3; k++) begin
      gap(idle);
      sample(1'b0);
      check({tag, "_x0"}, x_out, 0);
      check({tag, "_v0"}, sym_valid, 0);
    end
  endtask

  // Full PRBS symbol period checked against the model
  task automatic prbs_symbol(input string tag, input int unsigned idle);
    model_symbol();
    gap(idle);
    sample(1'b0);
    check({tag, "_x"}, x_out, level(m_sym));
    check({tag, "_sym"}, sym_out, m_sym);
    check({tag, "_v"}, sym_valid, 1);
    zeros(tag, idle);
  endtask

  task automatic first_eight(input string tag);
    m_lfsr = 15'h0001;
    // From seed 1 the first two symbols are both 00 -> -LVL_HI
    gap(3);
    sample(1'b0);
    model_symbol();
    check({tag, "_s0_x"}, x_out, -98304);
    check({tag, "_s0_sym"}, sym_out, 0);
    check({tag, "_s0_v"}, sym_valid, 1);
    gap(1);
    check({tag, "_pulse"}, sym_valid, 0);
    check({tag, "_hold"}, x_out, -98304);
    gap(2);
    zeros({tag, "_s0"}, 3);
    gap(3);
    sample(1'b0);
    model_symbol();
    check({tag, "_s1_x"}, x_out, -98304);
    check({tag, "_s1_v"}, sym_valid, 1);
    zeros({tag, "_s1"}, 3);
  endtask

  initial begin
    reset      = 1'b0;
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    mode       = 2'b00;
    m_sym      = '0;
    m_lfsr     = 15'h0001;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_x", x_out, 0);
    check("rst_sym", sym_out, 0);
    check("rst_v", sym_valid, 0);
    check("rst_aerr", align_err, 0);
    reset = 1'b1;

    // First eight samples after reset, enable every 4 sys_clk
    first_eight("init");

    // Longer PRBS run, enable every sys_clk
    for (int i = 0; i < 300; i++) prbs_symbol("prbs", 0);
    check("prbs_aerr", align_err, 0);

    // Mode 00 -> 10 at ph=1
    prbs_symbol("pre_const", 0);
    gap(1);
    model_symbol();
    sample(1'b0);
    check("m10_ph0_x", x_out, level(m_sym));
    mode = 2'b10;
    for (int k = 0; k < 3; k++) begin
      sample(1'b0);
      check("m10_mid_x", x_out, 0);
    end
    sample(1'b0);
    check("m10_x", x_out, 98304);
    check("m10_sym", sym_out, 2);
    check("m10_v", sym_valid, 1);
    zeros("m10", 0);

    // Silent symbol, then impulse
    mode = 2'b11;
    sample(1'b0);
    check("m11_x", x_out, 0);
    check("m11_v", sym_valid, 0);
    zeros("m11", 0);
    mode = 2'b01;
    sample(1'b0);
    check("imp1_x", x_out, 131071);
    check("imp1_sym", sym_out, 2);
    check("imp1_v", sym_valid, 1);
    zeros("imp1", 0);
    for (int s = 0; s < 16; s++) begin
      sample(1'b0);
      check("imp_tail_x", x_out, 0);
      check("imp_tail_v", sym_valid, 1);
      zeros("imp_tail", 0);
    end
    mode = 2'b11;
    sample(1'b0);
    zeros("m11b", 0);
    mode = 2'b01;
    sample(1'b0);
    check("imp2_x", x_out, 131071);
    zeros("imp2", 0);

    // LFSR was frozen through modes 01/10/11
    mode = 2'b00;
    prbs_symbol("resume", 0);

    // Early sym_clk_en at ph=2
    prbs_symbol("pre_align", 0);
    model_symbol();
    sample(1'b0);
    check("al_ph0_x", x_out, level(m_sym));
    sample(1'b0);
    check("al_ph1_x", x_out, 0);
    model_symbol();
    sample(1'b1);
    check("al_x", x_out, level(m_sym));
    check("al_sym", sym_out, m_sym);
    check("al_v", sym_valid, 1);
    check("al_err", align_err, 1);
    zeros("al", 0);
    prbs_symbol("post_align", 0);
    check("al_sticky", align_err, 1);

    // Asynchronous reset mid-symbol, while outputs are non-zero
    model_symbol();
    sample(1'b0);
    check("pre_rst_x", x_out, level(m_sym));
    #2;
    reset = 1'b0;
    #1;
    check("arst_x", x_out, 0);
    check("arst_sym", sym_out, 0);
    check("arst_v", sym_valid, 0);
    check("arst_aerr", align_err, 0);
    gap(2);
    reset = 1'b1;
    first_eight("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ask_symbol_source.md
ASK_SYMBOL_SOURCE -- requirements
Module: ask_symbol_source

Interface
REQ-001 Parameter SPS, default 4: sam_clk_en pulses per symbol period.
REQ-002 Parameter LVL_LO, default 18'sd32768: inner 4-ASK magnitude, s1.17.
REQ-003 Parameter LVL_HI, default 18'sd98304: outer 4-ASK magnitude, s1.17.
REQ-004 Parameter IMP_AMP, default 18'sd131071: impulse amplitude, s1.17.
REQ-005 Parameter SEED, default 15'h0001: LFSR reset value; SHALL be non-zero.
REQ-006 sys_clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 sam_clk_en  input  1  one-sys_clk-wide sample-rate enable.
REQ-009 sym_clk_en  input  1  one-sys_clk-wide symbol-rate enable, coincident with every SPS-th sam_clk_en.
REQ-010 mode  input  2  00 PRBS, 01 impulse, 10 constant +LVL_HI, 11 silent.
REQ-011 x_out  output  18  signed s1.17 upsampled sample feeding the pulse-shaping filter input.
REQ-012 sym_out  output  2  current symbol bits {b1,b0}.
REQ-013 sym_valid  output  1  one-sys_clk pulse when a new symbol is emitted.
REQ-014 align_err  output  1  sticky: sym_clk_en arrived off the internal symbol phase.

Function
REQ-015 Block SHALL be a zero-stuffing upsampler: on a symbol-phase sam_clk_en x_out takes the symbol level; on the other SPS-1 sam_clk_en x_out = 0.
REQ-016 x_out, sym_out, sym_valid SHALL be registered, updating only on sys_clk edges where sam_clk_en=1; x_out holds between enables; latency one sys_clk from the enable.
REQ-017 Phase counter ph (0..SPS-1) SHALL increment on each sam_clk_en, wrapping SPS-1 -> 0; ph=0 is symbol phase.
REQ-018 sym_clk_en with sam_clk_en SHALL force ph to 0 (resync); if ph would not already have wrapped to 0, align_err SHALL set and hold until reset.
REQ-019 sym_clk_en without sam_clk_en SHALL be ignored apart from setting align_err.
REQ-020 LFSR: 15-bit Fibonacci, polynomial x^15+x^14+1, shifting exactly twice per symbol (PRBS mode only); b1 = first bit out, b0 = second.
REQ-021 If the LFSR ever holds zero it SHALL reload SEED on the next symbol phase.
REQ-022 Gray mapping: 00 -> -LVL_HI, 01 -> -LVL_LO, 11 -> +LVL_LO, 10 -> +LVL_HI; negation exact two's complement, no saturation.
REQ-023 mode SHALL be sampled only at symbol phase; changes mid-symbol take effect at the next ph=0.
REQ-024 Impulse mode: FSM IDLE -> FIRE -> DONE; entering mode 01 from another mode SHALL emit IMP_AMP at the first symbol-phase sample, then zeros indefinitely (DONE); leaving mode 01 returns to IDLE; re-entering re-arms.
REQ-025 Mode 10 SHALL emit +LVL_HI at symbol phase, zeros elsewhere; mode 11 SHALL emit 0 always; LFSR frozen in modes 01/10/11.
REQ-026 sym_valid SHALL pulse at each symbol-phase emission in every mode except 11; sym_out = 2'b10 in modes 01 and 10.

Reset
REQ-027 reset low SHALL asynchronously force x_out=0, sym_out=0, sym_valid=0, align_err=0, ph=SPS-1, LFSR=SEED, impulse FSM=IDLE.
REQ-028 After reset release the first sam_clk_en SHALL be a symbol phase (ph wraps to 0).
REQ-029 reset asserted mid-symbol SHALL abandon the symbol; no partial output after release.

Verification
REQ-030 Reset, mode=00, SPS=4, sam_clk_en every 4 sys_clk -> first 8 samples: symbol level, 0, 0, 0, next level, 0, 0, 0; symbols follow the LFSR from 15'h0001.
REQ-031 PRBS mode 32767 symbols -> LFSR returns to SEED; histogram of sym_out within ±1% of uniform.
REQ-032 mode=01 after reset -> x_out = 131071 for exactly one sample, then 0 for ≥64 samples; toggle mode 11->01 -> second impulse.
REQ-033 sym_clk_en injected at ph=2 -> align_err=1 and stays 1; next sample is symbol phase.
REQ-034 mode changed 00->10 at ph=1 -> remaining samples of that symbol are 0, next symbol phase outputs 98304.
REQ-035 reset pulsed low mid-symbol -> all outputs 0 immediately (asynchronous), sequence restarts per REQ-030.
